// File: rtl/accumulator.sv
// accumulator: WIDTH-bit load/hold register for the CPU datapath.
// Captures data_in when load_acc is high at a rising clk edge, holds
// otherwise, and provides zero/sign status flags from the stored value.
module accumulator #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_acc,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             acc_zero,
    output logic             acc_neg
);

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_q;

    // Next-value select: data_in only when loading, so data_in never reaches the flops otherwise
    always_comb begin
        acc_d = acc_q;
        if (load_acc) begin
            acc_d = data_in;
        end else begin
            acc_d = acc_q;
        end
    end

    // State register; asynchronous reset always wins over a coincident load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= RESET_VALUE;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Outputs come straight from the register so flags never see data_in
    assign acc_out  = acc_q;
    assign acc_zero = (acc_q == {WIDTH{1'b0}});
    assign acc_neg  = acc_q[WIDTH-1];

endmodule

// File: tb/tb_accumulator.sv
// tb_accumulator: directed plus randomized checks of accumulator against a
// simple value model (reset clears, load copies, otherwise hold).
module tb_accumulator;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         load_acc;
    logic [W-1:0] data_in;
    logic [W-1:0] acc_out;
    logic         acc_zero;
    logic         acc_neg;

    int total;
    int bad;
    int model;   // expected register contents as a plain integer

    accumulator #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_acc (load_acc),
        .data_in  (data_in),
        .acc_out  (acc_out),
        .acc_zero (acc_zero),
        .acc_neg  (acc_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all three outputs against the model value
    task automatic check_all(input string tag);
        check({tag, ".out"},  {24'd0, acc_out},  model);
        check({tag, ".zero"}, {31'd0, acc_zero}, (model == 0) ? 32'd1 : 32'd0);
        check({tag, ".neg"},  {31'd0, acc_neg},  (model >= 128) ? 32'd1 : 32'd0);
    endtask

    // One rising edge: apply the behavioural rule, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        if (reset === 1'b1)
            model = 0;
        else if (load_acc === 1'b1)
            model = int'(data_in);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; model = 0;
        reset = 1'b1; load_acc = 1'b0; data_in = 8'h00;

        // Power-up under reset, including a load attempt while reset is high
        step(); step();
        check_all("por");
        load_acc = 1'b1; data_in = 8'h5A;
        step(); step();
        check_all("por_load_blocked");

        // Release reset, load 0xFF for one edge
        reset = 1'b0; data_in = 8'hFF; load_acc = 1'b1;
        step();
        load_acc = 1'b0;
        check_all("load_ff");

        // Load 0xAA, then data changes with load low must be ignored
        data_in = 8'hAA; load_acc = 1'b1;
        step();
        check_all("load_aa");
        load_acc = 1'b0; data_in = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("hold_aa");
        end

        // Asynchronous reset pulse between edges
        #2;
        reset = 1'b1; model = 0;
        #1;
        check_all("async_reset");
        #1;
        reset = 1'b0;
        step(); step();
        check_all("after_reset_no_load");

        // Back-to-back loads, ending with zero
        load_acc = 1'b1;
        data_in = 8'h01; step(); check_all("b2b_01");
        data_in = 8'h7F; step(); check_all("b2b_7f");
        data_in = 8'h80; step(); check_all("b2b_80");
        data_in = 8'h00; step(); check_all("b2b_00");
        load_acc = 1'b0;

        // Give the register a nonzero value, then reset collides with a load of 0x33
        data_in = 8'hC3; load_acc = 1'b1; step(); check_all("pre_collide");
        data_in = 8'h33; load_acc = 1'b1;
        #2;
        reset = 1'b1; model = 0;
        #1;
        check_all("collide_async");
        step();
        check_all("collide_edge");
        reset = 1'b0; load_acc = 1'b0;
        step();
        check_all("collide_after");

        // Unknown data while load is low must not reach the register
        data_in = 8'h96; load_acc = 1'b1; step(); check_all("pre_x");
        load_acc = 1'b0; data_in = 8'bxxxx_zzzz;
        step(); step();
        check_all("x_hold");

        // Randomized load/hold/reset traffic
        for (int i = 0; i < 300; i++) begin
            load_acc = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            data_in  = 8'($urandom_range(0, 255));
            reset    = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            if (reset) model = 0;
            step();
            check_all("rand");
        end
        reset = 1'b0; load_acc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
